// File: rtl/cache_refill_controller_pkg.sv
// Shared definitions for the cache refill controller: FSM encoding, line field
// offsets and address helpers.
package cache_refill_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL,
        ST_COMMIT
    } state_e;

    // Line layout is {tag, data, valid, dirty} with dirty at bit 0.
    localparam int DIRTY_BIT = 0;
    localparam int VALID_BIT = 1;
    localparam int DATA_LSB  = 2;

    function automatic int tag_lsb(input int block_offset);
        return DATA_LSB + (8 << block_offset);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int index_bits,
                                             input int block_offset);
        return addr >> (index_bits + block_offset);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int block_offset,
                                               input int index_bits);
        return (addr >> block_offset) & ((64'd1 << index_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] line_base(input logic [63:0] tag,
                                              input logic [63:0] index,
                                              input int index_bits,
                                              input int block_offset);
        return (tag << (index_bits + block_offset)) | (index << block_offset);
    endfunction

endpackage

// File: rtl/cache_refill_controller_if.sv
// Cache-side and memory-bus-side signals of the refill controller. The
// controller connects through the master modport, its environment through slave.
interface cache_refill_controller_if #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDR_BITS    = 32,
    parameter int INDEX_BITS   = 5,
    parameter int BLOCK_OFFSET = 6
) ();
    localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - BLOCK_OFFSET;
    localparam int LINE_LENGTH = TAG_BITS + 8 * (2 ** BLOCK_OFFSET) + 2;

    logic                   miss_req;
    logic [ADDR_BITS-1:0]   miss_addr;
    logic [LINE_LENGTH-1:0] victim_line;
    logic [LINE_LENGTH-1:0] fill_line;
    logic                   fill_we;
    logic                   miss_done;
    logic                   busy;
    logic [ADDR_BITS-1:0]   ext_addr;
    logic [WORD_SIZE-1:0]   ext_wdata;
    logic [WORD_SIZE-1:0]   ext_rdata;
    logic                   ext_re;
    logic                   ext_wr;
    logic                   ext_ack;

    modport master (
        input  miss_req, miss_addr, victim_line, ext_rdata, ext_ack,
        output fill_line, fill_we, miss_done, busy,
               ext_addr, ext_wdata, ext_re, ext_wr
    );

    modport slave (
        output miss_req, miss_addr, victim_line, ext_rdata, ext_ack,
        input  fill_line, fill_we, miss_done, busy,
               ext_addr, ext_wdata, ext_re, ext_wr
    );

endinterface

// File: rtl/cache_refill_controller_miss_line_buffer.sv
// One-line word buffer: parallel load of the victim, indexed fill writes, an
// indexed read for write-back and a whole-line view that includes a pending write.
module miss_line_buffer #(
    parameter int WORD_SIZE      = 32,
    parameter int WORDS_PER_LINE = 16,
    parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic                                clk,
    input  logic                                load_i,
    input  logic [WORDS_PER_LINE*WORD_SIZE-1:0] load_data_i,
    input  logic                                wr_en_i,
    input  logic [IDX_W-1:0]                    wr_idx_i,
    input  logic [WORD_SIZE-1:0]                wr_data_i,
    input  logic [IDX_W-1:0]                    rd_idx_i,
    output logic [WORD_SIZE-1:0]                rd_data_o,
    output logic [WORDS_PER_LINE*WORD_SIZE-1:0] line_o
);

    logic [WORD_SIZE-1:0] mem_q [WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (load_i) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                mem_q[i] <= load_data_i[i*WORD_SIZE +: WORD_SIZE];
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

    // Bypass lets the final fill word join the committed line on the same edge.
    always_comb begin
        line_o = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
                line_o[i*WORD_SIZE +: WORD_SIZE] = wr_data_i;
            end else begin
                line_o[i*WORD_SIZE +: WORD_SIZE] = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/cache_refill_controller.sv
// Miss handler: optional dirty-victim write-back burst, line refill over a
// per-word acked bus, then a one-cycle commit of the new line into the cache.
module cache_refill_controller
    import cache_refill_controller_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int ADDR_BITS    = 32,
    parameter int INDEX_BITS   = 5,
    parameter int BLOCK_OFFSET = 6
) (
    input logic                       clk,
    input logic                       rst_n,
    cache_refill_controller_if.master bus
);

    localparam int BYTES_PER_WORD = WORD_SIZE / 8;
    localparam int WORDS_PER_LINE = (2 ** BLOCK_OFFSET) / BYTES_PER_WORD;
    localparam int TAG_BITS       = ADDR_BITS - INDEX_BITS - BLOCK_OFFSET;
    localparam int DATA_BITS      = 8 * (2 ** BLOCK_OFFSET);
    localparam int LINE_LENGTH    = TAG_BITS + DATA_BITS + 2;
    localparam int CNT_W          = $clog2(WORDS_PER_LINE);
    localparam int TAG_LSB        = tag_lsb(BLOCK_OFFSET);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDR_BITS-1:0]   miss_base_q;
    logic [LINE_LENGTH-1:0] fill_line_q;
    logic                   fill_we_q;
    logic                   miss_done_q;
    logic                   busy_q;
    logic [ADDR_BITS-1:0]   ext_addr_q;
    logic [WORD_SIZE-1:0]   ext_wdata_q;
    logic                   ext_re_q;
    logic                   ext_wr_q;

    logic [TAG_BITS-1:0]    victim_tag;
    logic [63:0]            miss_index;
    logic [ADDR_BITS-1:0]   miss_base_d;
    logic [ADDR_BITS-1:0]   victim_base_d;
    logic                   victim_wb;
    logic                   accept;
    logic                   fill_wr;
    logic                   last_word;
    logic [WORD_SIZE-1:0]   wb_word;
    logic [DATA_BITS-1:0]   line_data;

    assign victim_tag    = bus.victim_line[TAG_LSB +: TAG_BITS];
    assign victim_wb     = bus.victim_line[VALID_BIT] & bus.victim_line[DIRTY_BIT];
    assign miss_index    = addr_index(64'(bus.miss_addr), BLOCK_OFFSET, INDEX_BITS);
    assign miss_base_d   = ADDR_BITS'(line_base(addr_tag(64'(bus.miss_addr), INDEX_BITS, BLOCK_OFFSET),
                                                miss_index, INDEX_BITS, BLOCK_OFFSET));
    assign victim_base_d = ADDR_BITS'(line_base(64'(victim_tag), miss_index, INDEX_BITS, BLOCK_OFFSET));
    assign accept        = (state_q == ST_IDLE) && bus.miss_req;
    assign fill_wr       = (state_q == ST_FILL) && bus.ext_ack;
    assign last_word     = (cnt_q == CNT_W'(WORDS_PER_LINE - 1));

    miss_line_buffer #(
        .WORD_SIZE      (WORD_SIZE),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_buf (
        .clk         (clk),
        .load_i      (accept),
        .load_data_i (bus.victim_line[DATA_LSB +: DATA_BITS]),
        .wr_en_i     (fill_wr),
        .wr_idx_i    (cnt_q),
        .wr_data_i   (bus.ext_rdata),
        .rd_idx_i    (cnt_q + CNT_W'(1)),
        .rd_data_o   (wb_word),
        .line_o      (line_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            miss_base_q <= '0;
            fill_line_q <= '0;
            fill_we_q   <= 1'b0;
            miss_done_q <= 1'b0;
            busy_q      <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_re_q    <= 1'b0;
            ext_wr_q    <= 1'b0;
        end else begin
            fill_we_q   <= 1'b0;
            miss_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.miss_req) begin
                        miss_base_q <= miss_base_d;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        if (victim_wb) begin
                            state_q     <= ST_WB;
                            ext_wr_q    <= 1'b1;
                            ext_addr_q  <= victim_base_d;
                            // Word 0 comes straight from the input; the buffer loads on this edge.
                            ext_wdata_q <= bus.victim_line[DATA_LSB +: WORD_SIZE];
                        end else begin
                            state_q    <= ST_FILL;
                            ext_re_q   <= 1'b1;
                            ext_addr_q <= miss_base_d;
                        end
                    end
                end
                ST_WB: begin
                    if (bus.ext_ack) begin
                        if (last_word) begin
                            state_q    <= ST_FILL;
                            cnt_q      <= '0;
                            ext_addr_q <= miss_base_q;
                            ext_wr_q   <= 1'b0;
                            ext_re_q   <= 1'b1;
                        end else begin
                            cnt_q       <= cnt_q + CNT_W'(1);
                            ext_addr_q  <= ext_addr_q + ADDR_BITS'(BYTES_PER_WORD);
                            ext_wdata_q <= wb_word;
                        end
                    end
                end
                ST_FILL: begin
                    if (bus.ext_ack) begin
                        if (last_word) begin
                            state_q     <= ST_COMMIT;
                            cnt_q       <= '0;
                            ext_re_q    <= 1'b0;
                            fill_we_q   <= 1'b1;
                            miss_done_q <= 1'b1;
                            fill_line_q <= {miss_base_q[ADDR_BITS-1 -: TAG_BITS], line_data, 1'b1, 1'b0};
                        end else begin
                            cnt_q      <= cnt_q + CNT_W'(1);
                            ext_addr_q <= ext_addr_q + ADDR_BITS'(BYTES_PER_WORD);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fill_line = fill_line_q;
    assign bus.fill_we   = fill_we_q;
    assign bus.miss_done = miss_done_q;
    assign bus.busy      = busy_q;
    assign bus.ext_addr  = ext_addr_q;
    assign bus.ext_wdata = ext_wdata_q;
    assign bus.ext_re    = ext_re_q;
    assign bus.ext_wr    = ext_wr_q;

endmodule

// File: doc/cache_refill_controller.md
# cache_refill_controller

Parametrised miss handler between the L1 cache array and the external word-wide memory bus. It replaces the single-purpose miss controller with a fully synchronous block that supports:
- configurable word, line and index geometry;
- write-back of a dirty victim line as a multi-word burst before the refill;
- a wait-state-tolerant per-word ack handshake;
- a single-cycle commit of the refilled line (tag, data, valid, dirty) into the cache.

## Interface
Parameters:
- WORD_SIZE, 32, bus word width in bits (multiple of 8)
- ADDR_BITS, 32, byte address width
- INDEX_BITS, 5, cache index bits
- BLOCK_OFFSET, 6, log2 of line size in bytes
- BYTES_PER_WORD, WORD_SIZE/8, derived
- WORDS_PER_LINE, 2**BLOCK_OFFSET/BYTES_PER_WORD, derived; power of two, at least 2
- TAG_BITS, ADDR_BITS-INDEX_BITS-BLOCK_OFFSET, derived
- LINE_LENGTH, TAG_BITS+8*2**BLOCK_OFFSET+2, line layout {tag, data, valid, dirty}, tag at MSBs

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- miss_req  in  1  level request from cache; sampled only in IDLE
- miss_addr  in  ADDR_BITS  missing byte address
- victim_line  in  LINE_LENGTH  line currently at miss index
- fill_line  out  LINE_LENGTH  refilled line, valid=1, dirty=0
- fill_we  out  1  one-cycle write strobe for fill_line
- miss_done  out  1  one-cycle completion pulse, coincident with fill_we
- busy  out  1  high in every non-IDLE state
- ext_addr  out  ADDR_BITS  word-aligned bus address
- ext_wdata  out  WORD_SIZE  write-back data
- ext_rdata  in  WORD_SIZE  read data, valid when ext_ack is high
- ext_re  out  1  read strobe
- ext_wr  out  1  write strobe
- ext_ack  in  1  completes the current word on the clk edge where it is high

## Operation
- States: IDLE, WB, FILL, COMMIT.
- IDLE, miss_req=1: latch miss_addr and victim_line. Then:
  - go to WB if victim valid&dirty, else FILL;
  - clear the word counter;
  - set ext_addr to the line base: {victim_tag, index, 0} for WB, {miss_tag, index, 0} for FILL.
- WB:
  - ext_wr=1; ext_wdata = latched victim data word[counter] (word 0 at data LSBs).
  - Each ack: counter+1, ext_addr+BYTES_PER_WORD.
  - Ack on word WORDS_PER_LINE-1: counter to 0, ext_addr to the miss line base, go to FILL.
- FILL:
  - ext_re=1. Each ack stores ext_rdata into word[counter], then advances counter and address as in WB.
  - Ack on the last word: go to COMMIT.
- COMMIT:
  - fill_line = {miss_tag, data, 1, 0}; fill_we=1, miss_done=1 for exactly one cycle.
  - Then go to IDLE.
- miss_req while busy is ignored. The cache drops miss_req on miss_done; a still-high miss_req in the following IDLE cycle starts a new miss.
- ext_ack outside WB/FILL is ignored.
- Address and data stay stable while a word is unacked. The strobe stays high across consecutive words and drops only on leaving WB/FILL.
- Counter width is $clog2(WORDS_PER_LINE). Address increments wrap modulo 2**ADDR_BITS. Offset bits of ext_addr below the word granularity are always 0.

## Timing
- All outputs are registered.
- Reset values: fill_line=0, fill_we=0, miss_done=0, busy=0, ext_addr=0, ext_wdata=0, ext_re=0, ext_wr=0; state IDLE.
- Accept edge E: strobe and busy high from E+1.
- With a zero-wait bus (ack every cycle):
  - clean miss: fill_we in cycle E+WORDS_PER_LINE+1;
  - dirty miss: fill_we in cycle E+2*WORDS_PER_LINE+1.
- Each bus wait cycle adds one cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously); partial data is discarded; no fill_we. After release, the block resumes from IDLE.

## Structure
- Shared package: state encoding, line field offsets (DIRTY_BIT=0, VALID_BIT=1, data LSB=2, tag LSB), and helper functions for tag/index extraction and line base address.
- Sub-module miss_line_buffer:
  - one WORDS_PER_LINE x WORD_SIZE register array;
  - indexed write on fill ack;
  - indexed read mux for the write-back word;
  - parallel load from victim_line on accept.

## Test plan
Default parameters (16 words/line, tag 21 bits).
- Clean miss: miss_addr=0x0000_1234, victim invalid, ack every cycle, rdata=0x100+i. Expect 16 ext_re words at 0x1200..0x123C; fill_we at E+17; fill_line tag=0x2, word i=0x100+i, valid=1, dirty=0.
- Dirty victim: tag=0x5, word i=0xA0+i, miss 0x1234. Expect 16 ext_wr words at 0x2A00..0x2A3C with data 0xA0+i, then 16 reads at 0x1200; fill_we at E+33.
- Valid clean victim: no ext_wr cycles; timing identical to the clean-miss case.
- Wait states: ack every 3rd cycle. Expect ext_addr/ext_wdata stable between acks; fill_we at E+49 (clean case).
- Reset after the 5th fill ack: all outputs 0 in the same cycle, no fill_we. Next miss after release completes with correct data.
- miss_req held high throughout: second request ignored while busy. A new miss starts in the cycle after miss_done; miss_done is a one-cycle pulse each time.
